// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//   ID/EX pipeline register with integrated load-use hazard detection.
//   Captures the decoded instruction from ID every cycle and presents it to EX
//   and to the forwarding unit. When the held instruction is a load whose rd
//   matches a source of the instruction in ID, it stalls PC and IF/ID and
//   loads a bubble. It also supports an EX-branch flush and a downstream hold.
//
//   Optional feature: define STALL_COUNT_EN to add a saturating 16-bit count
//   of load-use stall cycles on port stall_cnt_o.
//
// Parameters
//   DATA_W      operand / immediate / PC width
//   REG_ADDR_W  register-specifier width
//   ALUOP_W     ALU-op control width
//
// Ports
//   clk, rst_n                 rising-edge clock, async active-low reset
//   id_valid_i                 ID holds a real instruction
//   id_rs1_i/id_rs2_i/id_rd_i  register specifiers from ID
//   id_ctrl_i                  {reg_write,mem_read,mem_write,mem_to_reg,alu_src}
//   id_aluop_i                 ALU operation
//   id_rdata1_i/id_rdata2_i    register-file read data
//   id_imm_i, id_pc_i          sign-extended immediate, PC+4
//   flush_i                    branch taken in EX; kill the ID instruction
//   hold_i                     downstream busy; freeze this stage
//   ex_*_o                     registered copies of the ID fields
//   load_use_o                 load-use hazard (combinational)
//   pc_write_o, if_id_write_o  PC and IF/ID update enables
//   stall_cnt_o                stall counter (STALL_COUNT_EN only)
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic [4:0]            id_ctrl_i,
    input  logic [ALUOP_W-1:0]    id_aluop_i,
    input  logic [DATA_W-1:0]     id_rdata1_i,
    input  logic [DATA_W-1:0]     id_rdata2_i,
    input  logic [DATA_W-1:0]     id_imm_i,
    input  logic [DATA_W-1:0]     id_pc_i,
    input  logic                  flush_i,
    input  logic                  hold_i,
    output logic                  ex_valid_o,
    output logic [REG_ADDR_W-1:0] ex_rs1_o,
    output logic [REG_ADDR_W-1:0] ex_rs2_o,
    output logic [REG_ADDR_W-1:0] ex_rd_o,
    output logic [4:0]            ex_ctrl_o,
    output logic [ALUOP_W-1:0]    ex_aluop_o,
    output logic [DATA_W-1:0]     ex_rdata1_o,
    output logic [DATA_W-1:0]     ex_rdata2_o,
    output logic [DATA_W-1:0]     ex_imm_o,
    output logic [DATA_W-1:0]     ex_pc_o,
    output logic                  load_use_o,
    output logic                  pc_write_o,
    output logic                  if_id_write_o
`ifdef STALL_COUNT_EN
    ,
    output logic [15:0]           stall_cnt_o
`endif
);

    // Position of mem_read inside {reg_write,mem_read,mem_write,mem_to_reg,alu_src}.
    localparam int CTRL_MEM_READ = 3;

    // Whole stage payload; a bubble is simply the all-zero value.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [4:0]            ctrl;
        logic [ALUOP_W-1:0]    aluop;
        logic [DATA_W-1:0]     rdata1;
        logic [DATA_W-1:0]     rdata2;
        logic [DATA_W-1:0]     imm;
        logic [DATA_W-1:0]     pc;
    } stage_t;

    stage_t id_in;
    stage_t ex_q;
    logic   load_use;

    assign id_in = '{
        valid:  id_valid_i,
        rs1:    id_rs1_i,
        rs2:    id_rs2_i,
        rd:     id_rd_i,
        ctrl:   id_ctrl_i,
        aluop:  id_aluop_i,
        rdata1: id_rdata1_i,
        rdata2: id_rdata2_i,
        imm:    id_imm_i,
        pc:     id_pc_i
    };

    // Hazard against the held instruction. Qualifying on ex_q.valid keeps a
    // bubble with stale fields from stalling; rd=0 is the hard-wired zero
    // register and never creates a dependency.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        load_use = 1'b0;
        if (ex_q.valid && ex_q.ctrl[CTRL_MEM_READ] && id_valid_i &&
            (ex_q.rd != '0) && ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i)))
            load_use = 1'b1;
    end

    assign load_use_o = load_use;

    // In reset the stage is a bubble and upstream must be free to advance,
    // regardless of hold_i.
    assign pc_write_o    = rst_n ? ~(load_use | hold_i) : 1'b1;
    assign if_id_write_o = pc_write_o;

    // Priority: flush > hold > load-use bubble > capture.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (!rst_n) begin
            ex_q <= '0;
        end else if (flush_i) begin
            ex_q <= '0;
        end else if (hold_i) begin
            ex_q <= ex_q;
        end else if (load_use) begin
            ex_q <= '0;
        end else begin
            ex_q <= id_in;
        end
    end

    assign ex_valid_o  = ex_q.valid;
    assign ex_rs1_o    = ex_q.rs1;
    assign ex_rs2_o    = ex_q.rs2;
    assign ex_rd_o     = ex_q.rd;
    assign ex_ctrl_o   = ex_q.ctrl;
    assign ex_aluop_o  = ex_q.aluop;
    assign ex_rdata1_o = ex_q.rdata1;
    assign ex_rdata2_o = ex_q.rdata2;
    assign ex_imm_o    = ex_q.imm;
    assign ex_pc_o     = ex_q.pc;

`ifdef STALL_COUNT_EN
    // Counts edges on which a load-use bubble is actually inserted.
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= '0;
        else if (load_use && !hold_i && !flush_i && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg
//   Directed-vector bench for id_ex_stage_reg. Inputs change just after the
//   rising edge; outputs are sampled 1 ns after the edge (registered) or after
//   inputs settle (combinational). Define STALL_COUNT_EN to also exercise the
//   stall counter.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg;

    logic        clk;
    logic        rst_n;
    logic        id_valid_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic [4:0]  id_ctrl_i;
    logic [3:0]  id_aluop_i;
    logic [31:0] id_rdata1_i, id_rdata2_i, id_imm_i, id_pc_i;
    logic        flush_i, hold_i;
    logic        ex_valid_o;
    logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
    logic [4:0]  ex_ctrl_o;
    logic [3:0]  ex_aluop_o;
    logic [31:0] ex_rdata1_o, ex_rdata2_o, ex_imm_o, ex_pc_o;
    logic        load_use_o, pc_write_o, if_id_write_o;
`ifdef STALL_COUNT_EN
    logic [15:0] stall_cnt_o;
`endif

    int n_cmp;
    int n_bad;

    localparam logic [4:0] CTRL_LW  = 5'b11010; // reg_write, mem_read, mem_to_reg
    localparam logic [4:0] CTRL_ADD = 5'b10000; // reg_write only

    id_ex_stage_reg dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid_i   (id_valid_i),
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .id_rd_i      (id_rd_i),
        .id_ctrl_i    (id_ctrl_i),
        .id_aluop_i   (id_aluop_i),
        .id_rdata1_i  (id_rdata1_i),
        .id_rdata2_i  (id_rdata2_i),
        .id_imm_i     (id_imm_i),
        .id_pc_i      (id_pc_i),
        .flush_i      (flush_i),
        .hold_i       (hold_i),
        .ex_valid_o   (ex_valid_o),
        .ex_rs1_o     (ex_rs1_o),
        .ex_rs2_o     (ex_rs2_o),
        .ex_rd_o      (ex_rd_o),
        .ex_ctrl_o    (ex_ctrl_o),
        .ex_aluop_o   (ex_aluop_o),
        .ex_rdata1_o  (ex_rdata1_o),
        .ex_rdata2_o  (ex_rdata2_o),
        .ex_imm_o     (ex_imm_o),
        .ex_pc_o      (ex_pc_o),
        .load_use_o   (load_use_o),
        .pc_write_o   (pc_write_o),
        .if_id_write_o(if_id_write_o)
`ifdef STALL_COUNT_EN
        ,
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive an ID instruction; remaining data fields are fixed per call.
    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [4:0] ctrl,
                            input logic [31:0] d1);
        id_valid_i  = v;
        id_rs1_i    = rs1;
        id_rs2_i    = rs2;
        id_rd_i     = rd;
        id_ctrl_i   = ctrl;
        id_aluop_i  = 4'h2;
        id_rdata1_i = d1;
        id_rdata2_i = 32'h0000_0BBB;
        id_imm_i    = 32'h0000_0CCC;
        id_pc_i     = 32'h0000_0DDC;
        #1;
    endtask

`ifdef STALL_COUNT_EN
    // One isolated load-use event: lw r5 enters EX, then a consumer of r5.
    task automatic load_use_event();
        drive_id(1'b1, 5'd1, 5'd2, 5'd5, CTRL_LW, 32'h1);
        step();
        drive_id(1'b1, 5'd5, 5'd3, 5'd8, CTRL_ADD, 32'h2);
        step();  // bubble inserted here
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
        step();
        step();
    endtask
`endif

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        flush_i = 1'b0;
        hold_i  = 1'b1;  // enables must still be 1 while in reset
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);

        // ---- Reset state ----
        step();
        step();
        check("rst_valid",     {31'b0, ex_valid_o},    32'h0);
        check("rst_ctrl",      {27'b0, ex_ctrl_o},     32'h0);
        check("rst_pc_write",  {31'b0, pc_write_o},    32'h1);
        check("rst_if_id",     {31'b0, if_id_write_o}, 32'h1);
        hold_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // ---- Pass-through ----
        step();
        id_valid_i  = 1'b1;
        id_rs1_i    = 5'd5;
        id_rs2_i    = 5'd6;
        id_rd_i     = 5'd7;
        id_ctrl_i   = CTRL_ADD;
        id_aluop_i  = 4'h3;
        id_rdata1_i = 32'h0000_00A5;
        id_rdata2_i = 32'h0000_005A;
        id_imm_i    = 32'hFFFF_FFF0;
        id_pc_i     = 32'h0000_0104;
        step();
        check("pt_valid",  {31'b0, ex_valid_o},  32'h1);
        check("pt_rs1",    {27'b0, ex_rs1_o},    32'd5);
        check("pt_rs2",    {27'b0, ex_rs2_o},    32'd6);
        check("pt_rd",     {27'b0, ex_rd_o},     32'd7);
        check("pt_ctrl",   {27'b0, ex_ctrl_o},   32'h10);
        check("pt_aluop",  {28'b0, ex_aluop_o},  32'h3);
        check("pt_rdata1", ex_rdata1_o,          32'h0000_00A5);
        check("pt_rdata2", ex_rdata2_o,          32'h0000_005A);
        check("pt_imm",    ex_imm_o,             32'hFFFF_FFF0);
        check("pt_pc",     ex_pc_o,              32'h0000_0104);

        // ---- Load-use on rs1 ----
        drive_id(1'b1, 5'd1, 5'd2, 5'd5, CTRL_LW, 32'h0000_0011);
        step();
        drive_id(1'b1, 5'd5, 5'd3, 5'd8, CTRL_ADD, 32'h0000_0111);
        check("lu_flag",     {31'b0, load_use_o},    32'h1);
        check("lu_pc_write", {31'b0, pc_write_o},    32'h0);
        check("lu_if_id",    {31'b0, if_id_write_o}, 32'h0);
        step();
        check("lu_bub_valid",  {31'b0, ex_valid_o}, 32'h0);
        check("lu_bub_ctrl",   {27'b0, ex_ctrl_o},  32'h0);
        check("lu_bub_rdata1", ex_rdata1_o,         32'h0);
        check("lu_released",   {31'b0, load_use_o}, 32'h0);
        check("lu_pc_back",    {31'b0, pc_write_o}, 32'h1);
        step();
        check("lu_cap_valid",  {31'b0, ex_valid_o}, 32'h1);
        check("lu_cap_rs1",    {27'b0, ex_rs1_o},   32'd5);
        check("lu_cap_rdata1", ex_rdata1_o,         32'h0000_0111);

        // ---- Load-use on rs2 ----
        drive_id(1'b1, 5'd1, 5'd2, 5'd9, CTRL_LW, 32'h0);
        step();
        drive_id(1'b1, 5'd4, 5'd9, 5'd8, CTRL_ADD, 32'h0);
        check("lu_rs2", {31'b0, load_use_o}, 32'h1);
        step();

        // ---- No false hazards ----
        drive_id(1'b1, 5'd1, 5'd2, 5'd0, CTRL_LW, 32'h0);  // lw r0
        step();
        drive_id(1'b1, 5'd0, 5'd0, 5'd8, CTRL_ADD, 32'h0);
        check("nf_rd0", {31'b0, load_use_o}, 32'h0);
        drive_id(1'b1, 5'd1, 5'd2, 5'd5, CTRL_ADD, 32'h0);  // add r5
        step();
        drive_id(1'b1, 5'd5, 5'd0, 5'd8, CTRL_ADD, 32'h0);
        check("nf_not_load", {31'b0, load_use_o}, 32'h0);
        drive_id(1'b0, 5'd1, 5'd2, 5'd5, CTRL_LW, 32'h0);  // invalid lw fields
        step();
        drive_id(1'b1, 5'd5, 5'd0, 5'd8, CTRL_ADD, 32'h0);
        check("nf_bubble_stale", {31'b0, load_use_o}, 32'h0);
        drive_id(1'b1, 5'd1, 5'd2, 5'd5, CTRL_LW, 32'h0);  // valid lw r5
        step();
        drive_id(1'b0, 5'd5, 5'd0, 5'd8, CTRL_ADD, 32'h0);  // ID invalid
        check("nf_id_invalid", {31'b0, load_use_o}, 32'h0);

        // ---- Flush wins over hold ----
        drive_id(1'b1, 5'd3, 5'd4, 5'd6, CTRL_ADD, 32'h0000_0333);
        step();
        flush_i = 1'b1;
        hold_i  = 1'b1;
        step();
        check("fl_valid",  {31'b0, ex_valid_o}, 32'h0);
        check("fl_ctrl",   {27'b0, ex_ctrl_o},  32'h0);
        check("fl_rdata1", ex_rdata1_o,         32'h0);
        flush_i = 1'b0;
        hold_i  = 1'b0;

        // ---- Hold alone for 3 cycles ----
        drive_id(1'b1, 5'd10, 5'd11, 5'd12, CTRL_ADD, 32'h0000_4444);
        step();
        hold_i = 1'b1;
        drive_id(1'b1, 5'd13, 5'd14, 5'd15, CTRL_LW, 32'h0000_5555);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hd_pc_write", {31'b0, pc_write_o}, 32'h0);
            check("hd_rd",       {27'b0, ex_rd_o},    32'd12);
            check("hd_rdata1",   ex_rdata1_o,         32'h0000_4444);
            check("hd_ctrl",     {27'b0, ex_ctrl_o},  32'h10);
        end
        hold_i = 1'b0;
        step();
        check("hd_release_rd", {27'b0, ex_rd_o}, 32'd15);

        // ---- Hold together with load-use: freeze, then bubble ----
        drive_id(1'b1, 5'd1, 5'd2, 5'd5, CTRL_LW, 32'h0000_0066);
        step();
        hold_i = 1'b1;
        drive_id(1'b1, 5'd5, 5'd2, 5'd8, CTRL_ADD, 32'h0000_0077);
        check("hl_flag", {31'b0, load_use_o}, 32'h1);
        step();
        check("hl_frozen_ctrl", {27'b0, ex_ctrl_o}, {27'b0, CTRL_LW});
        check("hl_pc_write",    {31'b0, pc_write_o}, 32'h0);
        hold_i = 1'b0;
        #1;
        check("hl_still_stall", {31'b0, pc_write_o}, 32'h0);
        step();
        check("hl_bubble", {31'b0, ex_valid_o}, 32'h0);
        step();
        check("hl_capture", ex_rdata1_o, 32'h0000_0077);

        // ---- Reset mid-stall ----
        drive_id(1'b1, 5'd1, 5'd2, 5'd5, CTRL_LW, 32'h0);
        step();
        drive_id(1'b1, 5'd5, 5'd2, 5'd8, CTRL_ADD, 32'h0);
        check("rs_pre_stall", {31'b0, load_use_o}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_valid",    {31'b0, ex_valid_o}, 32'h0);
        check("rs_ctrl",     {27'b0, ex_ctrl_o},  32'h0);
        check("rs_load_use", {31'b0, load_use_o}, 32'h0);
        check("rs_pc_write", {31'b0, pc_write_o}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
        step();

`ifdef STALL_COUNT_EN
        // ---- Stall counter ----
        check("sc_reset", {16'b0, stall_cnt_o}, 32'h0);
        for (int i = 0; i < 3; i++) load_use_event();
        check("sc_three", {16'b0, stall_cnt_o}, 32'd3);
        @(negedge clk);
        dut.stall_cnt_q = 16'hFFFE;
        #1;
        load_use_event();
        load_use_event();
        check("sc_saturate", {16'b0, stall_cnt_o}, 32'h0000_FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
